// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester and consumer handshake bundle for rr_mux_arbiter (RR_MUX_ARBITER_PACKET_LOCK_EN adds in_last/out_last)
interface rr_mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_ready;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [$clog2(N)-1:0] out_grant;
  logic out_ready;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  logic [N-1:0] in_last;
  logic out_last;
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_grant, out_last
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_valid, out_data, out_grant, out_last
  );
`else
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_grant
  );
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_grant
  );
`endif
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 arbiter over a 2:1 mux tree with a registered output beat (RR_MUX_ARBITER_PACKET_LOCK_EN adds packet lock)
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int GW = $clog2(N);
  localparam int P = 1 << GW;
  logic [GW-1:0] last_q, last_d, grant_q, grant_d, win, idx;
  logic valid_q, valid_d, found, load, take;
  logic [W-1:0] data_q, data_d;
  logic [N-1:0] cand;
  logic [W-1:0] node [1:2*P-1];
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  logic lock_q, lock_d, olast_q, olast_d;
  // while locked, last_q is the packet owner, so only it may compete
  assign cand = lock_q ? bus.in_valid & (N'(1) << last_q) : bus.in_valid;
  assign bus.out_last = olast_q;
`else
  assign cand = bus.in_valid;
`endif
  assign load = !valid_q || bus.out_ready;
  assign take = load && found;
  assign bus.in_ready = (take && !rst) ? N'(1) << win : '0;
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_grant = grant_q;
  // first candidate found scanning upward from last_q+1 with wrap-around
  always_comb begin
    found = 1'b0;
    win = last_q;
    idx = last_q;
    for (int i = 1; i <= N; i++) begin
      idx = GW'((int'(last_q) + i) % N);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_in
      assign node[P+i] = bus.in_data[i*W +: W];
    end else begin : g_pad
      assign node[P+i] = '0;
    end
  end
  for (genvar l = 0; l < GW; l++) begin : g_lvl
    for (genvar j = 0; j < (1 << l); j++) begin : g_mux
      assign node[(1 << l) + j] = win[GW-1-l] ? node[2*((1 << l) + j) + 1] : node[2*((1 << l) + j)];
    end
  end
  // output stage reloads whenever it is empty or being drained
  always_comb begin
    valid_d = load ? found : valid_q;
    data_d = take ? node[1] : data_q;
    grant_d = take ? win : grant_q;
    last_d = take ? win : last_q;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    lock_d = take ? !bus.in_last[win] : lock_q;
    olast_d = take ? bus.in_last[win] : olast_q;
`endif
  end
  // state registers with synchronous reset; requester 0 first after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      grant_q <= '0;
      last_q <= GW'(N - 1);
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      lock_q <= 1'b0;
      olast_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      grant_q <= grant_d;
      last_q <= last_d;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      lock_q <= lock_d;
      olast_q <= olast_d;
`endif
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed vector table, corner sequences and randomized model check for rr_mux_arbiter
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  typedef struct {
    logic [3:0] v;
    logic r;
    logic [3:0] rdy;
    logic ov;
    int g;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  vec_t tv[$];
  logic [3:0] lk_v [6] = '{4'h1, 4'h7, 4'h7, 4'h7, 4'h5, 4'h1};
  logic [3:0] lk_l [6] = '{4'hF, 4'hD, 4'hD, 4'hF, 4'hF, 4'hF};
  logic [3:0] lk_r [6] = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h1};
  int lk_g [6] = '{0, 1, 1, 1, 2, 0};
  logic lk_ol [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  bit [3:0] pv;
  logic [7:0] pd [4];
  bit pl [4];
  int wx [4];
  bit m_ov, m_l, m_lock;
  logic [7:0] m_d;
  int m_g, m_last, m_lk, win;
  logic ordy, load;
  logic [3:0] exp_rdy;
  logic [31:0] dv;
  rr_mux_arbiter_if #(.N(N), .W(W)) bus ();
  rr_mux_arbiter #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [3:0] v, input logic r, input logic [3:0] rdy, input logic ov, input int g);
    tv.push_back('{v, r, rdy, ov, g});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = '0;
    bus.in_data = 32'hD3C2B1A0;
    bus.out_ready = 1'b0;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    bus.in_last = 4'hF;
`endif
    add(4'hF, 1, 4'h1, 1, 0); add(4'hF, 1, 4'h2, 1, 1); add(4'hF, 1, 4'h4, 1, 2);
    add(4'hF, 1, 4'h8, 1, 3); add(4'hF, 1, 4'h1, 1, 0);
    for (int i = 0; i < 5; i++) add(4'h4, 1, 4'h4, 1, 2);
    add(4'h2, 1, 4'h2, 1, 1);
    for (int i = 0; i < 3; i++) add(4'hF, 0, 4'h0, 1, 1);
    add(4'hF, 1, 4'h4, 1, 2);
    add(4'h8, 1, 4'h8, 1, 3); add(4'h9, 1, 4'h1, 1, 0); add(4'h9, 1, 4'h8, 1, 3);
    add(4'h0, 1, 4'h0, 0, 0); add(4'h2, 0, 4'h2, 1, 1); add(4'h0, 0, 4'h0, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_grant", bus.out_grant, 0);
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    chk("reset_out_last", bus.out_last, 0);
`endif
    for (int i = 0; i < tv.size(); i++) begin
      bus.in_valid = tv[i].v;
      bus.out_ready = tv[i].r;
      #1;
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, tv[i].rdy);
      tick();
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, tv[i].ov);
      if (tv[i].ov) begin
        chk($sformatf("vec%0d_out_grant", i), bus.out_grant, tv[i].g);
        chk($sformatf("vec%0d_out_data", i), bus.out_data, 8'(8'hA0 + 8'h11 * tv[i].g));
      end
    end
    rst = 1'b1;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b0;
    #1;
    chk("midreset_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_out_grant", bus.out_grant, 0);
    bus.in_valid = 4'h6;
    bus.out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", bus.in_ready, 4'h2);
    tick();
    chk("post_reset_grant", bus.out_grant, 1);
    chk("post_reset_data", bus.out_data, 8'hB1);
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = lk_v[i];
      bus.in_last = lk_l[i];
      #1;
      chk($sformatf("lock%0d_in_ready", i), bus.in_ready, lk_r[i]);
      tick();
      chk($sformatf("lock%0d_grant", i), bus.out_grant, lk_g[i]);
      chk($sformatf("lock%0d_out_last", i), bus.out_last, lk_ol[i]);
    end
`endif
    bus.in_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pv = '0;
    m_ov = 0; m_d = '0; m_g = 0; m_last = N - 1; m_l = 0; m_lock = 0; m_lk = 0;
    for (int k = 0; k < N; k++) begin
      pd[k] = '0; pl[k] = 0; wx[k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pv[k] && $urandom_range(0, 2) != 0) begin
          pv[k] = 1;
          pd[k] = 8'($urandom);
          pl[k] = 1'($urandom);
          wx[k] = 0;
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) dv[k*8 +: 8] = pd[k];
      bus.in_valid = pv;
      bus.in_data = dv;
      bus.out_ready = ordy;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      bus.in_last = {3'(0), 1'(pl[0])} | ({3'(0), 1'(pl[1])} << 1) | ({3'(0), 1'(pl[2])} << 2) | ({3'(0), 1'(pl[3])} << 3);
`endif
      load = !m_ov || ordy;
      win = -1;
      for (int o = 1; o <= N; o++) begin
        int k;
        k = (m_last + o) % N;
        if (win < 0 && pv[k] && (!m_lock || k == m_lk)) win = k;
      end
      exp_rdy = (load && win >= 0) ? 4'(1 << win) : 4'h0;
      #1;
      chk($sformatf("rand%0d_in_ready", c), bus.in_ready, exp_rdy);
      tick();
      if (load) begin
        if (win >= 0) begin
`ifndef RR_MUX_ARBITER_PACKET_LOCK_EN
          chk($sformatf("rand%0d_fair_wait", c), wx[win] <= N - 1, 1);
`endif
          m_ov = 1; m_d = pd[win]; m_g = win; m_last = win; m_l = pl[win];
          m_lock = LOCK && !pl[win];
          m_lk = win;
          pv[win] = 0;
          for (int k = 0; k < N; k++) if (pv[k]) wx[k]++;
        end else begin
          m_ov = 0;
        end
      end
      chk($sformatf("rand%0d_out_valid", c), bus.out_valid, m_ov);
      if (m_ov) begin
        chk($sformatf("rand%0d_out_grant", c), bus.out_grant, m_g);
        chk($sformatf("rand%0d_out_data", c), bus.out_data, m_d);
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
        chk($sformatf("rand%0d_out_last", c), bus.out_last, m_l);
`endif
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
